mux_2: RTL and testbench



---
 rtl/mux_2_pkg.sv | 23 ++
 rtl/mux_2_reg.sv | 58 +++++
 rtl/mux_2.sv | 86 ++++++++
 tb/tb_mux_2.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_2_pkg.sv
// mux_2_pkg: load-mode codes shared by the read-data lane mux and the memory block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   mode_t     - 2-bit load mode / lane-select code
//   MODE_BYTE  - byte access, upper lane forced to zero by the caller
//   MODE_HALF  - half-word access, upper byte of the addressed half-word
//   MODE_WORD  - word access, byte 1 of the word
//   MODE_DWORD - reserved double-word code, caller ties its input to zero
package mux_2_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_BYTE  = 2'b00;
   localparam mode_t MODE_HALF  = 2'b01;
   localparam mode_t MODE_WORD  = 2'b10;
   localparam mode_t MODE_DWORD = 2'b11;

   // Number of select bits the lane mux is built for (four candidates).
   localparam int MODE_WIDTH = 2;

endpackage : mux_2_pkg

// File: rtl/mux_2_reg.sv
// mux_2_reg: registered copy of the lane-mux result, its select, and a change strobe.
// Latency: 1 cycle from y/sel to y_q/sel_q/chg.
// Backpressure: none; the inputs are sampled on every rising clk edge.
//
// Ports:
//   clk   - clock
//   clr   - asynchronous active-high clear of all three registers
//   y     - combinational mux result to be registered (WIDTH bits)
//   sel   - select code used to produce y
//   y_q   - registered y
//   sel_q - registered sel
//   chg   - high for one cycle when y_q was loaded with a value different from its previous one
//
// This block is only instantiated when MUX_2_REG_OUT_EN is defined.
module mux_2_reg
   import mux_2_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] y,
   input  mode_t            sel,
   output logic [WIDTH-1:0] y_q,
   output mode_t            sel_q,
   output logic             chg
);

   logic [WIDTH-1:0] y_d;
   mode_t            sel_d;
   logic             chg_d;
   logic             chg_q;

   // chg compares the incoming value with the one currently held, so after a
   // clear the first non-zero load strobes against the cleared value of zero.
   always_comb begin
      y_d   = y;
      sel_d = sel;
      chg_d = (y != y_q);
   end

   // clr wins over a coincident clk edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         y_q   <= '0;
         sel_q <= MODE_BYTE;
         chg_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         sel_q <= sel_d;
         chg_q <= chg_d;
      end
   end

   assign chg = chg_q;

endmodule : mux_2_reg

// File: rtl/mux_2.sv
// mux_2: 4-way WIDTH-bit lane mux steering load-result byte lane [15:8] by load mode.
// Latency: y is combinational (0 cycles); y_q/sel_q/chg are 1 cycle when MUX_2_REG_OUT_EN is defined.
// Backpressure: none; no handshake, inputs are taken every cycle.
//
// Ports (declaration order keeps six-port positional instances valid):
//   in0..in3 - candidate lanes for sel = 00/01/10/11 (in0 and in3 are tied to zero by the caller)
//   sel      - load mode (mode_t codes from mux_2_pkg)
//   y        - combinational selected lane
//   clk, clr - clock and asynchronous active-high clear, used by the registered path only
//   y_q      - registered y            (zero unless MUX_2_REG_OUT_EN)
//   sel_q    - registered sel          (zero unless MUX_2_REG_OUT_EN)
//   chg      - one-cycle change strobe (zero unless MUX_2_REG_OUT_EN)
//
// Build option: define MUX_2_REG_OUT_EN to compile in the registered copy and change detector.
module mux_2
   import mux_2_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SEL_WIDTH = 2
)
(
   input  logic [WIDTH-1:0]     in0,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   input  logic [WIDTH-1:0]     in3,
   input  logic [SEL_WIDTH-1:0] sel,
   output logic [WIDTH-1:0]     y,
   input  logic                 clk,
   input  logic                 clr,
   output logic [WIDTH-1:0]     y_q,
   output logic [SEL_WIDTH-1:0] sel_q,
   output logic                 chg
);

   // The mux is hard-wired for four candidates.
   if (SEL_WIDTH != MODE_WIDTH) begin : g_bad_sel_width
      $error("mux_2: SEL_WIDTH must be 2");
   end

   mode_t mode;
   assign mode = mode_t'(sel);

   // The default arm is reached only for an unknown select; it propagates X
   // in simulation and leaves synthesis free to treat the case as don't-care.
   always_comb begin
      y = '0;
      case (mode)
         MODE_BYTE:  y = in0;
         MODE_HALF:  y = in1;
         MODE_WORD:  y = in2;
         MODE_DWORD: y = in3;
         default:    y = 'x;
      endcase
   end

`ifdef MUX_2_REG_OUT_EN

   mode_t sel_reg;

   mux_2_reg #(
      .WIDTH (WIDTH)
   ) u_reg (
      .clk   (clk),
      .clr   (clr),
      .y     (y),
      .sel   (mode),
      .y_q   (y_q),
      .sel_q (sel_reg),
      .chg   (chg)
   );

   assign sel_q = SEL_WIDTH'(sel_reg);

`else

   // Combinational-only build: no state, registered outputs held at zero.
   assign y_q   = '0;
   assign sel_q = '0;
   assign chg   = 1'b0;

   logic unused_clk_clr;
   assign unused_clk_clr = ^{clk, clr};

`endif

endmodule : mux_2

// File: tb/tb_mux_2.sv
// tb_mux_2: directed vectors for mux_2 (8-bit and 16-bit instances) with a scoreboard.
// Latency: checks y with no delay and the registered outputs one clk edge after loading.
// Backpressure: n/a.
module tb_mux_2;

   logic [7:0]  in0, in1, in2, in3, y, y_q;
   logic [1:0]  sel, sel_q;
   logic        chg;
   logic        clk, clr;

   logic [15:0] w_in0, w_in1, w_in2, w_in3, w_y, w_y_q;
   logic [1:0]  w_sel, w_sel_q;
   logic        w_chg;

   mux_2 #(.WIDTH(8), .SEL_WIDTH(2)) dut (
      .in0(in0), .in1(in1), .in2(in2), .in3(in3), .sel(sel), .y(y),
      .clk(clk), .clr(clr), .y_q(y_q), .sel_q(sel_q), .chg(chg)
   );

   mux_2 #(.WIDTH(16), .SEL_WIDTH(2)) dut_w (
      .in0(w_in0), .in1(w_in1), .in2(w_in2), .in3(w_in3), .sel(w_sel), .y(w_y),
      .clk(clk), .clr(clr), .y_q(w_y_q), .sel_q(w_sel_q), .chg(w_chg)
   );

   // Which DUT output an expectation refers to.
   localparam int K_Y     = 0;
   localparam int K_WY    = 1;
   localparam int K_YQ    = 2;
   localparam int K_SELQ  = 3;
   localparam int K_CHG   = 4;

   typedef struct {
      int          kind;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t sbq[$];
   logic smp;
   int   n_cmp;
   int   n_bad;

   function automatic logic [15:0] actual(int kind);
      case (kind)
         K_Y:    return {8'h00, y};
         K_WY:   return w_y;
         K_YQ:   return {8'h00, y_q};
         K_SELQ: return {14'h0000, sel_q};
         K_CHG:  return {15'h0000, chg};
         default: return 16'hxxxx;
      endcase
   endfunction

   task automatic push(int kind, logic [15:0] e, string nm);
      exp_t t;
      t.kind = kind;
      t.exp  = e;
      t.name = nm;
      sbq.push_back(t);
   endtask

   // Let combinational outputs settle, then hand the queue to the monitor.
   task automatic sample();
      #1;
      smp = 1'b1;
      #1;
      smp = 1'b0;
      #1;
   endtask

   task automatic tick();
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
   endtask

   task automatic push_regs(logic [7:0] e_yq, logic [1:0] e_selq, logic e_chg, string nm);
      push(K_YQ,   {8'h00, e_yq},     {nm, "_y_q"});
      push(K_SELQ, {14'h0000, e_selq}, {nm, "_sel_q"});
      push(K_CHG,  {15'h0000, e_chg},  {nm, "_chg"});
   endtask

   // Monitor: drains every pending expectation against the live DUT outputs.
   initial begin : monitor
      exp_t        t;
      logic [15:0] a;
      forever begin
         @(posedge smp);
         while (sbq.size() > 0) begin
            t = sbq.pop_front();
            a = actual(t.kind);
            n_cmp++;
            if (a !== t.exp) begin
               n_bad++;
               $display("FAIL %s: got %h, expected %h", t.name, a, t.exp);
            end
         end
      end
   end

   // Directed comb vectors: {in0, in1, in2, in3, sel, expected y}.
   typedef struct {
      logic [7:0] i0, i1, i2, i3;
      logic [1:0] s;
      logic [7:0] e;
   } vec_t;

   vec_t vecs[8];

   initial begin : stim
      n_cmp = 0;
      n_bad = 0;
      smp   = 1'b0;
      clk   = 1'b0;
      clr   = 1'b1;
      in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00; sel = 2'b00;
      w_in0 = 16'h0000; w_in1 = 16'h0000; w_in2 = 16'h0000; w_in3 = 16'h0000; w_sel = 2'b00;

      // Reset state of the registered outputs (zero in either build).
      push_regs(8'h00, 2'b00, 1'b0, "reset");
      sample();
      clr = 1'b0;
      #2;

      // Load-path pattern, then distinct lanes so every leg is identifiable.
      vecs[0] = '{8'h00, 8'hAB, 8'h12, 8'h00, 2'b00, 8'h00};
      vecs[1] = '{8'h00, 8'hAB, 8'h12, 8'h00, 2'b01, 8'hAB};
      vecs[2] = '{8'h00, 8'hAB, 8'h12, 8'h00, 2'b10, 8'h12};
      vecs[3] = '{8'h00, 8'hAB, 8'h12, 8'h00, 2'b11, 8'h00};
      vecs[4] = '{8'h11, 8'h22, 8'h44, 8'h88, 2'b00, 8'h11};
      vecs[5] = '{8'h11, 8'h22, 8'h44, 8'h88, 2'b01, 8'h22};
      vecs[6] = '{8'h11, 8'h22, 8'h44, 8'h88, 2'b10, 8'h44};
      vecs[7] = '{8'h11, 8'h22, 8'h44, 8'h88, 2'b11, 8'h88};
      for (int i = 0; i < 8; i++) begin
         in0 = vecs[i].i0; in1 = vecs[i].i1; in2 = vecs[i].i2; in3 = vecs[i].i3;
         sel = vecs[i].s;
         push(K_Y, {8'h00, vecs[i].e}, $sformatf("comb_v%0d", i));
         sample();
      end

      // 16-bit instance: full width passes through untouched.
      w_in0 = 16'h0001; w_in1 = 16'h1234; w_in2 = 16'hBEEF; w_in3 = 16'h8000;
      w_sel = 2'b10;
      push(K_WY, 16'hBEEF, "w16_sel10");
      sample();
      w_sel = 2'b01;
      push(K_WY, 16'h1234, "w16_sel01");
      sample();
      w_sel = 2'b11;
      push(K_WY, 16'h8000, "w16_sel11");
      sample();

`ifdef MUX_2_REG_OUT_EN
      // Registered path: first load strobes chg against the cleared value.
      in0 = 8'h00; in1 = 8'hAB; in2 = 8'h5A; in3 = 8'h00; sel = 2'b10;
      tick();
      push_regs(8'h5A, 2'b10, 1'b1, "load1");
      sample();
      tick();
      push_regs(8'h5A, 2'b10, 1'b0, "hold");
      sample();

      // Clear between edges acts immediately.
      clr = 1'b1;
      push_regs(8'h00, 2'b00, 1'b0, "clr_async");
      push(K_Y, 16'h005A, "clr_y_comb");
      sample();
      clr = 1'b0;
      #2;
      tick();
      push_regs(8'h5A, 2'b10, 1'b1, "after_clr");
      sample();

      // Select change to a different value strobes again.
      sel = 2'b01;
      tick();
      push_regs(8'hAB, 2'b01, 1'b1, "sel_change");
      sample();

      // clr and clk rising together: clear wins.
      clr = 1'b1;
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
      push_regs(8'h00, 2'b00, 1'b0, "clr_clk_same");
      sample();
      clr = 1'b0;
      #2;
`else
      // Combinational-only build: registered outputs stay zero while clocking.
      for (int i = 0; i < 4; i++) begin
         in0 = 8'h11; in1 = 8'h22; in2 = 8'h44; in3 = 8'h88;
         sel = 2'(i);
         tick();
         push_regs(8'h00, 2'b00, 1'b0, $sformatf("noreg_%0d", i));
         push(K_Y, {8'h00, vecs[4 + i].e}, $sformatf("noreg_y_%0d", i));
         sample();
      end
`endif

      #5;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mux_2
